// File: rtl/writeback_commit.sv
// Writeback/commit stage: retires EX_WB bundles into the 32x32 register file, serves two
// bypassed read ports, and squashes a fixed number of wrong-path bundles after a taken branch.
module writeback_commit #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [70:0]         ex_wb,
    input  logic [4:0]          rd_addr_a,
    output logic [31:0]         rd_data_a,
    input  logic [4:0]          rd_addr_b,
    output logic [31:0]         rd_data_b,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                flushing,
    output logic [RETIRE_W-1:0] retired_count,
    output logic [15:0]         squashed_count
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    localparam logic [2:0]          FlushInit = 3'(FLUSH_DEPTH);
    localparam logic [RETIRE_W-1:0] RetOne    = 1;

    state_e               r_state, w_state_next;
    logic [2:0]           r_cnt, w_cnt_next;
    logic [31:0]          r_rf [32];
    logic                 r_redirect_valid;
    logic [31:0]          r_redirect_pc;
    logic [RETIRE_W-1:0]  r_retired;
    logic [15:0]          r_squashed;

    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic [4:0]  w_dest;
    logic        w_branch;
    logic        w_we;
    logic        w_commit;
    logic        w_squash;
    logic        w_byp;
    logic        w_wr;

    assign w_data   = ex_wb[31:0];
    assign w_pc     = ex_wb[63:32];
    assign w_dest   = ex_wb[68:64];
    assign w_branch = ex_wb[69];
    assign w_we     = ex_wb[70];

    assign w_commit = in_valid & (r_state == StRun);
    assign w_squash = in_valid & (r_state == StFlush);
    assign w_byp    = w_commit & w_we;
    assign w_wr     = w_byp & (w_dest != 5'd0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_commit && w_branch && (FlushInit != 3'd0)) begin
            w_state_next = StFlush;
            w_cnt_next   = FlushInit;
        end else if (w_squash) begin
            w_cnt_next = r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
                w_state_next = StRun;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StRun;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else if (w_wr) begin
            r_rf[w_dest] <= w_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_retired        <= '0;
            r_squashed       <= 16'd0;
        end else begin
            r_redirect_valid <= w_commit & w_branch;
            if (w_commit && w_branch) begin
                r_redirect_pc <= w_pc;
            end
            if (w_commit) begin
                r_retired <= r_retired + RetOne;
            end
            if (w_squash) begin
                r_squashed <= r_squashed + 16'd1;
            end
        end
    end

    assign rd_data_a = (rd_addr_a == 5'd0)                 ? 32'd0  :
                       (w_byp && (w_dest == rd_addr_a))    ? w_data :
                                                             r_rf[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0)                 ? 32'd0  :
                       (w_byp && (w_dest == rd_addr_b))    ? w_data :
                                                             r_rf[rd_addr_b];

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flushing       = (r_state == StFlush);
    assign retired_count  = r_retired;
    assign squashed_count = r_squashed;

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Final pipeline stage. Consumes the 71-bit EX_WB bundle produced by execute.
- Commits results into the 32x32 architectural register file.
- Exposes two bypassed read ports to decode.
- On a taken branch, issues a PC redirect to fetch and squashes wrong-path bundles for a fixed number of valid beats.

Parameters:
- FLUSH_DEPTH, 2, number of valid bundles squashed after a taken branch (0 = no squash; legal range 0..7)
- RETIRE_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX_WB bundle valid this cycle
- ex_wb  in  71  [31:0] wbdata, [63:32] pc/target, [68:64] dest addr, [69] branch flag, [70] writeback enable
- rd_addr_a  in  5  decode read port A address
- rd_data_a  out  32  read port A data (combinational)
- rd_addr_b  in  5  decode read port B address
- rd_data_b  out  32  read port B data (combinational)
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  32  branch target
- flushing  out  1  high while in FLUSH state
- retired_count  out  RETIRE_W  committed bundles, wrapping
- squashed_count  out  16  squashed bundles, wrapping

Behaviour:
- Reset (async, reset_n=0) clears the following immediately, regardless of clock:
  - all 32 registers to 0;
  - redirect_valid=0, redirect_pc=0;
  - state=RUN, flush counter=0;
  - retired_count=0, squashed_count=0.
- Reset mid-FLUSH aborts the flush. The first post-reset bundle commits normally.
- States: RUN, FLUSH. flushing = (state==FLUSH).
- A bundle is "committed" at a rising edge when in_valid=1 and state==RUN. It is "squashed" when in_valid=1 and state==FLUSH.
- Commit:
  - If ex_wb[70]=1 and dest!=0: rf[dest] <= ex_wb[31:0].
  - Writes to r0 are discarded; r0 always reads 0.
  - retired_count increments by 1, wrapping.
- Branch on commit: if ex_wb[69]=1, then at the same edge:
  - redirect_valid <= 1 and redirect_pc <= ex_wb[63:32];
  - if FLUSH_DEPTH>0: state <= FLUSH and counter <= FLUSH_DEPTH.
  - A bundle with both [69] and [70] set performs both the write and the redirect.
- redirect_valid is high for exactly one cycle, then returns to 0. redirect_pc holds its value until the next redirect.
- FLUSH:
  - Each squashed bundle: no rf write, no redirect (a branch flag is ignored), squashed_count +1, counter -1.
  - When the counter decrements to 0, state <= RUN at that edge. The next valid bundle commits.
  - Cycles with in_valid=0 do not decrement the counter.
- Latency: a committed write is visible on read ports from the cycle after the edge. Same-cycle visibility is via bypass only.
- Read ports are combinational, with this priority:
  - addr==0 -> 0;
  - else if in_valid & state==RUN & ex_wb[70] & ex_wb[68:64]==addr -> ex_wb[31:0] (bypass);
  - else rf[addr].
- Squashed bundles never bypass.
- Both ports may read the same address simultaneously. Each applies the rules independently.
- Counters wrap silently at all-ones -> 0. No saturation, no overflow flag.

Test Plan:
- Reset release then bundle {valid, [70]=1, dest=5, data=0xDEADBEEF} -> after edge, rd_addr_a=5 gives 0xDEADBEEF; retired_count=1.
- Bundle {[70]=1, dest=0, data=0x1234} -> rd_data for addr 0 stays 0; retired_count increments.
- Same cycle: in_valid with dest=7, data=0xA5A5A5A5; rd_addr_a=7 -> rd_data_a=0xA5A5A5A5 combinationally before the edge.
- Branch bundle with pc=0x00000040, FLUSH_DEPTH=2, followed by three valid writes to r1, r2, r3 (values 1, 2, 3):
  - redirect_valid pulses one cycle with redirect_pc=0x40;
  - r1 and r2 remain 0, r3=3;
  - squashed_count=2, flushing high for exactly the two squash beats.
- In FLUSH with in_valid gaps: valid, idle, idle, valid -> state returns to RUN only after the second valid. A squashed bundle carrying [69]=1 produces no redirect.
- Assert reset_n=0 asynchronously mid-FLUSH with r4=9 -> flushing and redirect_valid drop immediately and r4 reads 0. The first bundle after release commits.
- Preload retired_count near all-ones via 2^RETIRE_W commits (use RETIRE_W=4 build), 16 commits -> wraps to 0.
